guess_entry_ctrl: RTL and testbench
===================================

Name: guess_entry_ctrl

Overview:
- Sequencer between the debounced 4x4 keypad path and the 4-digit Digitron display.
- Consumes one-cycle key events (hex code), assembles a 3-digit BCD guess, and compares it with a target on Enter.
- Counts tries and drives the display's data/tries fields plus a status LED.
- Owns all game state; the keypad and display blocks stay stateless with respect to the game.

Parameters:
- DIGITS, 3, number of BCD digits in a guess (data width = 4*DIGITS).
- MAX_TRIES, 9, tries allowed per game (1..15).
- BLINK_DIV, 25_000_000, clk cycles per LED toggle in WIN/LOSE.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle pulse per debounced key press.
- key_code  in  4  hex key code; 0-9 digit, A enter, B backspace, C clear, D new game, E/F ignored.
- target  in  4*DIGITS  BCD target; sampled only at new-game.
- data  out  4*DIGITS  BCD digits for display; digit 0 in [3:0].
- tries  out  4  tries used this game.
- result  out  2  00 none, 01 too low, 10 too high, 11 equal.
- game_state  out  2  00 ENTRY, 01 WIN, 10 LOSE.
- light  out  1  status LED.

Behaviour:
- Reset (async, rst=1): data=0, tries=0, result=00, game_state=ENTRY, light=0, digit count=0, latched target=0.
- All outputs are registered and update the cycle after the key_valid cycle (latency 1). key_code is ignored when key_valid=0.
- FSM ENTRY:
  - Digit with count<DIGITS: shift left one nibble, insert digit at [3:0], count+1.
  - Digit with count=DIGITS: ignored.
  - B with count>0: shift right one nibble, upper nibble=0, count-1. B with count=0: no-op.
  - C: data=0, count=0, result unchanged.
  - A with count<DIGITS: ignored; tries unchanged.
  - A with count=DIGITS: tries+1; compare data with latched target as unsigned BCD magnitude (compare nibbles from MSB).
    - Equal: result=11, next WIN.
    - Not equal and the new tries value equals MAX_TRIES: result=01/10, next LOSE.
    - Otherwise: result=01/10, data=0, count=0, stay in ENTRY.
- WIN/LOSE:
  - All keys except D are ignored; data holds the last guess.
  - light toggles every BLINK_DIV cycles. In ENTRY light=(count==DIGITS).
- D in any state: new game. Next cycle data=0, count=0, tries=0, result=00, ENTRY, target latched from the target port, blink counter cleared, light=0.
- tries saturates at MAX_TRIES; it can never exceed MAX_TRIES.
- Non-BCD target nibbles are compared as raw binary with no error flag.
- Asynchronous reset mid-entry discards the partial guess; latched target returns to 0 until the next D.

Optional Feature:
- RANDOM_TARGET_EN defined: an internal 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) free-runs every clk cycle.
  - At new-game, each 4-bit slice is reduced mod 10 to form the BCD target.
  - The target port is present but ignored.
- RANDOM_TARGET_EN undefined: no LFSR logic; the target port is latched as described above.

Decomposition:
- Package guess_pkg holds:
  - KEY_ENTER=4'hA, KEY_BACK=4'hB, KEY_CLEAR=4'hC, KEY_NEW=4'hD.
  - game_state encodings ST_ENTRY/ST_WIN/ST_LOSE.
  - result encodings RES_NONE/RES_LOW/RES_HIGH/RES_EQ.
- One sub-module: bcd_compare (combinational, DIGITS-parameterised; outputs lt/eq/gt). The LFSR stays inline.

Test Plan:
- Reset, D with target=12'h472, keys 4,7,2,A -> result=11, game_state=WIN, tries=1, data=12'h472, light toggles after 25_000_000 cycles.
- Target 12'h500, keys 3,0,0,A -> result=01, tries=1, data=0. Then keys 9,0,0,A -> result=10, tries=2.
- Keys 1,2,B,3 -> data=12'h013, count=2. A -> ignored, tries unchanged. Keys 4,5 -> data=12'h134 (5 ignored, full).
- MAX_TRIES=2, target 12'h111, two wrong full guesses -> game_state=LOSE, tries=2. Further keys 1,A -> no change. D -> ENTRY, tries=0.
- Assert rst for one cycle between the 2nd and 3rd digit -> all outputs 0 immediately and asynchronously; the following digit enters as the first digit.
- RANDOM_TARGET_EN: two D presses 1000 cycles apart -> latched targets differ and every nibble is <=9.

Source files
------------

// File: rtl/guess_pkg.sv
// Shared key codes, game/result encodings and helpers for the guess-entry sequencer.
package guess_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_NEW   = 4'hD;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'b00,
        ST_WIN   = 2'b01,
        ST_LOSE  = 2'b10
    } game_state_e;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_LOW  = 2'b01,
        RES_HIGH = 2'b10,
        RES_EQ   = 2'b11
    } result_e;

    function automatic logic [3:0] nib_mod10(input logic [3:0] v);
        return (v >= 4'd10) ? v - 4'd10 : v;
    endfunction

endpackage

// File: rtl/bcd_compare.sv
// Combinational magnitude compare of two DIGITS-nibble values, most significant nibble first.
module bcd_compare #(
    parameter int unsigned DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                lt,
    output logic                eq,
    output logic                gt
);

    always_comb begin
        lt = 1'b0;
        gt = 1'b0;
        // The first differing nibble from the top decides; lower nibbles are then ignored.
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (!lt && !gt) begin
                lt = a[4*i +: 4] < b[4*i +: 4];
                gt = a[4*i +: 4] > b[4*i +: 4];
            end
        end
        eq = !lt && !gt;
    end

endmodule

// File: rtl/guess_entry_ctrl.sv
// Number-guess game sequencer: assembles keypad digits into a BCD guess and scores it.
// Define RANDOM_TARGET_EN to draw the target from an internal LFSR instead of the target port.
module guess_entry_ctrl
    import guess_pkg::*;
#(
    parameter int unsigned DIGITS    = 3,
    parameter int unsigned MAX_TRIES = 9,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic [4*DIGITS-1:0] target,
    output logic [4*DIGITS-1:0] data,
    output logic [3:0]          tries,
    output logic [1:0]          result,
    output logic [1:0]          game_state,
    output logic                light
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned BW = $clog2(BLINK_DIV + 1);

    localparam logic [CW-1:0] FULL       = CW'(DIGITS);
    localparam logic [3:0]    TRIES_MAX  = 4'(MAX_TRIES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    game_state_e   state_q;
    result_e       result_q;
    result_e       miss_res;
    logic [CW-1:0] count_q;
    logic [W-1:0]  target_q;
    logic [BW-1:0] blink_q;
    logic [W-1:0]  new_target;
    logic [3:0]    tries_inc;
    logic          lt, eq, gt;

    assign game_state = state_q;
    assign result     = result_q;

    bcd_compare #(
        .DIGITS(DIGITS)
    ) u_cmp (
        .a (data),
        .b (target_q),
        .lt(lt),
        .eq(eq),
        .gt(gt)
    );

    assign miss_res  = lt ? RES_LOW : (gt ? RES_HIGH : RES_EQ);
    assign tries_inc = (tries == TRIES_MAX) ? tries : tries + 4'd1;

`ifdef RANDOM_TARGET_EN
    logic [15:0] lfsr_q;
    logic        unused_target;

    assign unused_target = ^target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Digits beyond four reuse the LFSR slices cyclically.
    always_comb begin
        new_target = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            new_target[4*i +: 4] = nib_mod10(lfsr_q[4*(i%4) +: 4]);
        end
    end
`else
    assign new_target = target;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data     <= '0;
            tries    <= '0;
            result_q <= RES_NONE;
            state_q  <= ST_ENTRY;
            light    <= 1'b0;
            count_q  <= '0;
            target_q <= '0;
            blink_q  <= '0;
        end else if (key_valid && key_code == KEY_NEW) begin
            data     <= '0;
            tries    <= '0;
            result_q <= RES_NONE;
            state_q  <= ST_ENTRY;
            light    <= 1'b0;
            count_q  <= '0;
            target_q <= new_target;
            blink_q  <= '0;
        end else begin
            unique case (state_q)
                ST_ENTRY: begin
                    if (key_valid) begin
                        if (key_code <= 4'd9) begin
                            if (count_q != FULL) begin
                                data    <= (data << 4) | W'(key_code);
                                count_q <= count_q + 1'b1;
                                light   <= (count_q == FULL - 1'b1);
                            end
                        end else if (key_code == KEY_BACK) begin
                            if (count_q != '0) begin
                                data    <= data >> 4;
                                count_q <= count_q - 1'b1;
                                light   <= 1'b0;
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            data    <= '0;
                            count_q <= '0;
                            light   <= 1'b0;
                        end else if (key_code == KEY_ENTER && count_q == FULL) begin
                            tries   <= tries_inc;
                            blink_q <= '0;
                            if (eq) begin
                                result_q <= RES_EQ;
                                state_q  <= ST_WIN;
                            end else begin
                                result_q <= miss_res;
                                if (tries_inc == TRIES_MAX) begin
                                    state_q <= ST_LOSE;
                                end else begin
                                    data    <= '0;
                                    count_q <= '0;
                                    light   <= 1'b0;
                                end
                            end
                        end
                    end
                end
                ST_WIN, ST_LOSE: begin
                    // Light enters the end state lit (guess was full) and blinks from there.
                    if (blink_q == BLINK_LAST) begin
                        blink_q <= '0;
                        light   <= ~light;
                    end else begin
                        blink_q <= blink_q + 1'b1;
                    end
                end
                default: state_q <= ST_ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Randomized and directed bench for guess_entry_ctrl against a queue-based game model.
module tb_guess_entry_ctrl;

    localparam int DIGITS = 3;
    localparam int MAXT   = 2;
    localparam int BD     = 20;
    localparam int W      = 4 * DIGITS;

    logic         clk;
    logic         rst;
    logic         key_valid;
    logic [3:0]   key_code;
    logic [W-1:0] target;
    logic [W-1:0] data;
    logic [3:0]   tries;
    logic [1:0]   result;
    logic [1:0]   game_state;
    logic         light;

    guess_entry_ctrl #(
        .DIGITS   (DIGITS),
        .MAX_TRIES(MAXT),
        .BLINK_DIV(BD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .target    (target),
        .data      (data),
        .tries     (tries),
        .result    (result),
        .game_state(game_state),
        .light     (light)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Game model: entered digits kept as a queue, most significant first.
    int           m_state;   // 0 entry, 1 win, 2 lose
    int           m_tries;
    int           m_result;
    int           m_digs[$];
    logic [W-1:0] m_target;
    int           m_wl;      // cycles spent in win/lose

    function automatic logic [W-1:0] m_data();
        logic [W-1:0] v = '0;
        foreach (m_digs[i]) v = v * 16 + W'(m_digs[i]);
        return v;
    endfunction

    function automatic logic m_light();
        if (m_state == 0) return m_digs.size() == DIGITS;
        return ((m_wl / BD) % 2) == 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_tries = 0; m_result = 0; m_wl = 0; m_target = '0;
        m_digs.delete();
    endtask

    task automatic model_step(input logic v, input logic [3:0] c, input logic [W-1:0] tgt);
        logic [W-1:0] g;
        if (m_state != 0) m_wl++;
        if (!v) return;
        if (c == 4'hD) begin
            model_reset();
            m_target = tgt;
            return;
        end
        if (m_state != 0) return;
        if (c <= 4'd9) begin
            if (m_digs.size() < DIGITS) m_digs.push_back(int'(c));
        end else if (c == 4'hB) begin
            if (m_digs.size() > 0) void'(m_digs.pop_back());
        end else if (c == 4'hC) begin
            m_digs.delete();
        end else if (c == 4'hA && m_digs.size() == DIGITS) begin
            g = m_data();
            m_tries = (m_tries < MAXT) ? m_tries + 1 : MAXT;
            if (g == m_target) begin
                m_result = 3; m_state = 1; m_wl = 0;
            end else begin
                m_result = (g < m_target) ? 1 : 2;
                if (m_tries == MAXT) begin
                    m_state = 2; m_wl = 0;
                end else begin
                    m_digs.delete();
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_data"}, 32'(data), 32'(m_data()));
        check_eq({tag, "_tries"}, 32'(tries), 32'(m_tries));
        check_eq({tag, "_result"}, 32'(result), 32'(m_result));
        check_eq({tag, "_state"}, 32'(game_state), 32'(m_state));
        check_eq({tag, "_light"}, 32'(light), 32'(m_light()));
    endtask

    task automatic step(input logic v, input logic [3:0] c);
        @(negedge clk);
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        model_step(v, c, target);
        #1;
        check_all("step");
    endtask

    task automatic press(input logic [3:0] c);
        step(1'b1, c);
    endtask

    task automatic guess(input logic [W-1:0] g);
        logic [W-1:0] t;
        t = g;
        for (int i = DIGITS - 1; i >= 0; i--) press(t[4*i +: 4]);
        press(4'hA);
    endtask

    task automatic new_game(input logic [W-1:0] t);
        target = t;
        press(4'hD);
    endtask

    int r;
    logic [W-1:0] t1, t2;

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = '0; target = '0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
`ifdef RANDOM_TARGET_EN
        press(4'hD);
        t1 = dut.target_q;
        repeat (1000) @(negedge clk);
        press(4'hD);
        t2 = dut.target_q;
        check_eq("rnd_differ", 32'(t1 != t2), 32'd1);
        for (int i = 0; i < DIGITS; i++) begin
            check_eq("rnd_nib1", 32'(t1[4*i +: 4] <= 4'd9), 32'd1);
            check_eq("rnd_nib2", 32'(t2[4*i +: 4] <= 4'd9), 32'd1);
        end
`else
        // Win on first try, then watch the light blink.
        new_game(12'h472);
        guess(12'h472);
        check_eq("win_result", 32'(result), 32'd3);
        check_eq("win_state", 32'(game_state), 32'd1);
        check_eq("win_tries", 32'(tries), 32'd1);
        check_eq("win_data", 32'(data), 32'h472);
        check_eq("win_light", 32'(light), 32'd1);
        repeat (BD - 1) step(1'b0, 4'h0);
        check_eq("blink_hold", 32'(light), 32'd1);
        step(1'b0, 4'h0);
        check_eq("blink_toggle", 32'(light), 32'd0);

        // Too low, then too high reaching the try limit.
        new_game(12'h500);
        guess(12'h300);
        check_eq("low_result", 32'(result), 32'd1);
        check_eq("low_tries", 32'(tries), 32'd1);
        check_eq("low_data", 32'(data), 32'h000);
        guess(12'h900);
        check_eq("high_result", 32'(result), 32'd2);
        check_eq("high_tries", 32'(tries), 32'd2);
        check_eq("lose_state", 32'(game_state), 32'd2);
        press(4'h1);
        press(4'hA);
        check_eq("lose_hold_data", 32'(data), 32'h900);
        check_eq("lose_hold_tries", 32'(tries), 32'd2);
        new_game(12'h111);
        check_eq("new_state", 32'(game_state), 32'd0);
        check_eq("new_tries", 32'(tries), 32'd0);

        // Editing keys.
        press(4'h1); press(4'h2); press(4'hB); press(4'h3);
        check_eq("edit_data", 32'(data), 32'h013);
        check_eq("edit_light", 32'(light), 32'd0);
        press(4'hA);
        check_eq("short_enter_tries", 32'(tries), 32'd0);
        press(4'h4);
        press(4'h5);
        check_eq("full_data", 32'(data), 32'h134);
        check_eq("full_light", 32'(light), 32'd1);
        press(4'hC);
        check_eq("clear_data", 32'(data), 32'h000);

        // Reset between the second and third digit.
        press(4'h5); press(4'h6);
        @(negedge clk);
        key_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        check_eq("async_rst_data", 32'(data), 32'h000);
        @(negedge clk);
        rst = 1'b0;
        press(4'h7);
        check_eq("post_rst_data", 32'(data), 32'h007);

        // Random play.
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) press(4'($urandom_range(0, 9)));
            else if (r < 70) press(4'hA);
            else if (r < 76) press(4'hB);
            else if (r < 79) press(4'hC);
            else if (r < 86) begin
                if ($urandom_range(0, 1) == 0) begin
                    for (int i = 0; i < DIGITS; i++) target[4*i +: 4] = 4'($urandom_range(0, 9));
                end else begin
                    target = W'($urandom);
                end
                press(4'hD);
            end else if (r < 90) press(4'($urandom_range(14, 15)));
            else step(1'b0, 4'($urandom));
        end
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
